eu_operand_fetch: RTL and testbench
===================================

// Module: eu_operand_fetch
// PURPOSE
//  Requester-side counterpart of the exec-unit y-buffer. Accepts one decoded instruction at a time, issues
//  op0/op1 read requests to the y-buffer and retries each one every cycle until it succeeds. Captures
//  operand data, then presents a complete operand bundle to the ALU via valid/ready.
//  Sits between the issue stage and the ALU inside each exec unit.
// PARAMETERS
//  OPCODE_BITS     4  width of ALU opcode carried through
//  STALL_CNT_BITS  4  width of saturating fetch-retry counter; stall_o asserts at all-ones
// PORTS
//  clk                  in   1        clock
//  reset_n              in   1        synchronous active-low reset
//  instr_valid_i        in   1        instruction offered
//  instr_ready_o        out  1        instruction accepted when valid&ready
//  instr_op0_addr_i     in   addr     op0 local address (type_alu_local_addr)
//  instr_op0_use_imm_i  in   1        op0 taken from imm, no fetch
//  instr_op0_imm_i      in   data     op0 immediate (type_exec_unit_data)
//  instr_op1_addr_i / instr_op1_use_imm_i / instr_op1_imm_i   as op0
//  instr_dest_addr_i    in   addr     result local address, passed through
//  instr_opcode_i       in   OPCODE_BITS  passed through
//  op0_req_addr_o       out  addr     y-buffer op0 request address
//  op0_req_addr_valid_o out  1        y-buffer op0 request strobe
//  op0_data_i           in   data     y-buffer op0 data, same-cycle response
//  op0_data_success_i   in   1        op0 data valid this cycle
//  op1_req_addr_o / op1_req_addr_valid_o / op1_data_i / op1_data_success_i   as op0
//  alu_valid_o          out  1        operand bundle valid
//  alu_ready_i          in   1        ALU consumes bundle
//  alu_op0_o, alu_op1_o out  data     operands
//  alu_dest_addr_o      out  addr     destination
//  alu_opcode_o         out  OPCODE_BITS
//  stall_o              out  1        retry counter saturated (perf/debug)
// BEHAVIOUR
//  Reset: one clock; reset is synchronous and active-low (clk, reset_n).
//  - While reset_n=0: all outputs are 0, the state is IDLE, and the retry counter is 0.
//  - An in-flight instruction is dropped on reset.
//  FSM states: IDLE, FETCH, ISSUE.
//  - IDLE: instr_ready_o=1. On instr_valid_i:
//    - latch addrs, dest and opcode.
//    - got0=use_imm0 with data=imm0; got1 likewise.
//    - next state = ISSUE if got0&got1, else FETCH.
//  - FETCH:
//    - opN_req_addr_valid_o = ~gotN; opN_req_addr_o = latched addr.
//    - If opN_req_addr_valid_o & opN_data_success_i: capture opN_data_i and set gotN.
//    - The two operands are independent. Both may succeed in the same cycle. A success arriving while
//      gotN=1 or valid=0 is ignored.
//    - Leave for ISSUE on the edge after both got flags are (or become) set.
//    - Failed cycles re-request the same address next cycle; there is no back-off and no abort.
//  - ISSUE:
//    - alu_valid_o=1; the bundle is held stable until alu_ready_i.
//    - No y-buffer requests are issued.
//    - instr_ready_o = alu_ready_i, so back-to-back acceptance is allowed. If handshakes occur on both
//      sides, the new instruction is loaded and the next state follows the IDLE rules.
//    - Otherwise alu_ready_i returns the block to IDLE.
//  Latency, accept cycle T:
//  - both imm: alu_valid_o at T+1.
//  - fetch succeeding first try: request at T+1, alu_valid_o at T+2.
//  - each failed retry adds 1 cycle.
//  Request outputs:
//  - Addresses hold their last value when the strobe is low; they are 0 after reset.
//  - op0 and op1 may carry the same address.
//  Retry counter:
//  - Cleared on accept.
//  - +1 per FETCH cycle in which either got flag is still 0 after the cycle's responses; saturates.
//  - stall_o = counter all-ones; it clears on the next accept.
//  The block never asserts instr_ready_o in FETCH.
// STRUCTURE
//  pkg_dtypes: reuse type_alu_local_addr and type_exec_unit_data; add type_eu_opcode and enum
//  type_opf_state {IDLE,FETCH,ISSUE}.
//  Sub-module eu_opf_slot, instantiated twice (op0/op1). It holds got flag, data reg and addr reg, and
//  provides load/capture logic and the req_valid output. The top level holds the FSM, pass-through regs
//  and retry counter.
// TESTING
//  1 Reset: hold reset_n=0 mid-FETCH with requests pending -> next cycle all outputs 0; after release
//    instr_ready_o=1 and no request strobes.
//  2 Both imm: accept op0=imm 5, op1=imm 7, opcode 3 at T -> alu_valid_o at T+1 with op0=5, op1=7,
//    opcode 3; no y-buffer requests.
//  3 Split success: op0 addr 2, op1 addr 3. op0 succeeds at T+1 (data AA) and op1 at T+3 (data BB) ->
//    op0 strobe only at T+1; op1 strobe T+1..T+3; alu_valid_o at T+4 with AA/BB.
//  4 Backpressure + back-to-back: alu_ready_i=0 for 3 cycles, then 1 with a second instr valid ->
//    bundle stable for all stall cycles; second instr accepted in the handshake cycle; no bubble when
//    both of its operands are imm.
//  5 Starvation: success held 0 for 20 cycles with STALL_CNT_BITS=4 -> stall_o rises after 15 failed
//    cycles and stays high; success then clears it on the next accept.
//  6 Spurious success: success asserted for an operand already captured or not requested -> captured
//    data unchanged.

Source files
------------

// File: rtl/eu_operand_fetch_pkg.sv
// Shared types for the exec-unit operand fetch block.
package eu_operand_fetch_pkg;
    localparam int ADDR_BITS   = 8;
    localparam int DATA_BITS   = 16;
    localparam int OPCODE_BITS = 4;

    typedef logic [ADDR_BITS-1:0]   type_alu_local_addr;
    typedef logic [DATA_BITS-1:0]   type_exec_unit_data;
    typedef logic [OPCODE_BITS-1:0] type_eu_opcode;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } type_opf_state;
endpackage

// File: rtl/eu_opf_slot.sv
// One operand slot: got flag, data and address registers, and the y-buffer request strobe.
module eu_opf_slot
    import eu_operand_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic               use_imm_i,
    input  type_exec_unit_data imm_i,
    input  type_alu_local_addr addr_i,
    input  logic               fetch_i,
    input  type_exec_unit_data data_i,
    input  logic               success_i,
    output type_alu_local_addr req_addr_o,
    output logic               req_valid_o,
    output logic               got_o,
    output type_exec_unit_data data_o
);
    logic               got_q, got_d;
    type_exec_unit_data data_q, data_d;
    type_alu_local_addr addr_q, addr_d;
    logic               capture;

    assign req_valid_o = fetch_i & ~got_q;
    assign capture     = req_valid_o & success_i;
    assign got_o       = got_q | capture;
    assign req_addr_o  = addr_q;
    assign data_o      = data_q;

    // The address register only moves for fetched operands so the request bus holds while idle.
    always_comb begin
        got_d  = got_q;
        data_d = data_q;
        addr_d = addr_q;
        if (load_i) begin
            got_d  = use_imm_i;
            data_d = imm_i;
            if (!use_imm_i) addr_d = addr_i;
        end else if (capture) begin
            got_d  = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            got_q  <= 1'b0;
            data_q <= '0;
            addr_q <= '0;
        end else begin
            got_q  <= got_d;
            data_q <= data_d;
            addr_q <= addr_d;
        end
    end
endmodule

// File: rtl/eu_operand_fetch.sv
// Operand fetch: accepts an instruction, retries y-buffer reads until both operands arrive, hands bundle to ALU.
module eu_operand_fetch
    import eu_operand_fetch_pkg::*;
#(
    parameter int OPCODE_BITS    = 4,
    parameter int STALL_CNT_BITS = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    input  type_alu_local_addr     instr_op0_addr_i,
    input  logic                   instr_op0_use_imm_i,
    input  type_exec_unit_data     instr_op0_imm_i,
    input  type_alu_local_addr     instr_op1_addr_i,
    input  logic                   instr_op1_use_imm_i,
    input  type_exec_unit_data     instr_op1_imm_i,
    input  type_alu_local_addr     instr_dest_addr_i,
    input  logic [OPCODE_BITS-1:0] instr_opcode_i,
    output type_alu_local_addr     op0_req_addr_o,
    output logic                   op0_req_addr_valid_o,
    input  type_exec_unit_data     op0_data_i,
    input  logic                   op0_data_success_i,
    output type_alu_local_addr     op1_req_addr_o,
    output logic                   op1_req_addr_valid_o,
    input  type_exec_unit_data     op1_data_i,
    input  logic                   op1_data_success_i,
    output logic                   alu_valid_o,
    input  logic                   alu_ready_i,
    output type_exec_unit_data     alu_op0_o,
    output type_exec_unit_data     alu_op1_o,
    output type_alu_local_addr     alu_dest_addr_o,
    output logic [OPCODE_BITS-1:0] alu_opcode_o,
    output logic                   stall_o
);
    type_opf_state             state_q, state_d;
    type_alu_local_addr        dest_q, dest_d;
    logic [OPCODE_BITS-1:0]    opcode_q, opcode_d;
    logic [STALL_CNT_BITS-1:0] cnt_q, cnt_d;
    logic ready_c, valid_c, accept, fetch, got0, got1, both_imm;

    assign fetch    = reset_n & (state_q == FETCH);
    assign both_imm = instr_op0_use_imm_i & instr_op1_use_imm_i;

    // Control outputs are forced low while reset_n is held, not just after the reset edge.
    assign instr_ready_o   = reset_n & ready_c;
    assign alu_valid_o     = reset_n & valid_c;
    assign accept          = instr_valid_i & instr_ready_o;
    assign stall_o         = reset_n & (&cnt_q);
    assign alu_dest_addr_o = dest_q;
    assign alu_opcode_o    = opcode_q;

    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        valid_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (instr_valid_i) state_d = both_imm ? ISSUE : FETCH;
            end
            FETCH: begin
                if (got0 && got1) state_d = ISSUE;
            end
            ISSUE: begin
                valid_c = 1'b1;
                ready_c = alu_ready_i;
                if (alu_ready_i) state_d = instr_valid_i ? (both_imm ? ISSUE : FETCH) : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dest_d   = dest_q;
        opcode_d = opcode_q;
        cnt_d    = cnt_q;
        if (accept) begin
            dest_d   = instr_dest_addr_i;
            opcode_d = instr_opcode_i;
            cnt_d    = '0;
        end else if (fetch && !(got0 && got1) && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            dest_q   <= '0;
            opcode_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
        end
    end

    eu_opf_slot u_slot0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (accept),
        .use_imm_i   (instr_op0_use_imm_i),
        .imm_i       (instr_op0_imm_i),
        .addr_i      (instr_op0_addr_i),
        .fetch_i     (fetch),
        .data_i      (op0_data_i),
        .success_i   (op0_data_success_i),
        .req_addr_o  (op0_req_addr_o),
        .req_valid_o (op0_req_addr_valid_o),
        .got_o       (got0),
        .data_o      (alu_op0_o)
    );

    eu_opf_slot u_slot1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (accept),
        .use_imm_i   (instr_op1_use_imm_i),
        .imm_i       (instr_op1_imm_i),
        .addr_i      (instr_op1_addr_i),
        .fetch_i     (fetch),
        .data_i      (op1_data_i),
        .success_i   (op1_data_success_i),
        .req_addr_o  (op1_req_addr_o),
        .req_valid_o (op1_req_addr_valid_o),
        .got_o       (got1),
        .data_o      (alu_op1_o)
    );
endmodule

// File: tb/tb_eu_operand_fetch.sv
// Directed, table-driven bench for eu_operand_fetch plus hand-written reset and back-to-back sequences.
module tb_eu_operand_fetch;
    import eu_operand_fetch_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic instr_valid_i, instr_ready_o;
    logic [7:0] instr_op0_addr_i, instr_op1_addr_i, instr_dest_addr_i;
    logic instr_op0_use_imm_i, instr_op1_use_imm_i;
    logic [15:0] instr_op0_imm_i, instr_op1_imm_i;
    logic [3:0] instr_opcode_i;
    logic [7:0] op0_req_addr_o, op1_req_addr_o;
    logic op0_req_addr_valid_o, op1_req_addr_valid_o;
    logic [15:0] op0_data_i, op1_data_i;
    logic op0_data_success_i, op1_data_success_i;
    logic alu_valid_o, alu_ready_i;
    logic [15:0] alu_op0_o, alu_op1_o;
    logic [7:0] alu_dest_addr_o;
    logic [3:0] alu_opcode_o;
    logic stall_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    eu_operand_fetch #(.OPCODE_BITS(4), .STALL_CNT_BITS(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_op0_addr_i(instr_op0_addr_i), .instr_op0_use_imm_i(instr_op0_use_imm_i),
        .instr_op0_imm_i(instr_op0_imm_i),
        .instr_op1_addr_i(instr_op1_addr_i), .instr_op1_use_imm_i(instr_op1_use_imm_i),
        .instr_op1_imm_i(instr_op1_imm_i),
        .instr_dest_addr_i(instr_dest_addr_i), .instr_opcode_i(instr_opcode_i),
        .op0_req_addr_o(op0_req_addr_o), .op0_req_addr_valid_o(op0_req_addr_valid_o),
        .op0_data_i(op0_data_i), .op0_data_success_i(op0_data_success_i),
        .op1_req_addr_o(op1_req_addr_o), .op1_req_addr_valid_o(op1_req_addr_valid_o),
        .op1_data_i(op1_data_i), .op1_data_success_i(op1_data_success_i),
        .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
        .alu_op0_o(alu_op0_o), .alu_op1_o(alu_op1_o),
        .alu_dest_addr_o(alu_dest_addr_o), .alu_opcode_o(alu_opcode_o),
        .stall_o(stall_o)
    );

    typedef struct {
        logic        use0;
        logic [15:0] imm0;
        logic [7:0]  addr0;
        int          fail0;
        logic [15:0] d0;
        logic        use1;
        logic [15:0] imm1;
        logic [7:0]  addr1;
        int          fail1;
        logic [15:0] d1;
        logic [7:0]  dest;
        logic [3:0]  opc;
        int          hold;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input vec_t v);
        instr_valid_i       = 1'b1;
        instr_op0_use_imm_i = v.use0;
        instr_op0_imm_i     = v.imm0;
        instr_op0_addr_i    = v.addr0;
        instr_op1_use_imm_i = v.use1;
        instr_op1_imm_i     = v.imm1;
        instr_op1_addr_i    = v.addr1;
        instr_dest_addr_i   = v.dest;
        instr_opcode_i      = v.opc;
    endtask

    task automatic idle_inputs();
        instr_valid_i      = 1'b0;
        alu_ready_i        = 1'b0;
        op0_data_success_i = 1'b0;
        op1_data_success_i = 1'b0;
        op0_data_i         = 16'hBAD0;
        op1_data_i         = 16'hBAD1;
    endtask

    // Apply one vector from IDLE; success is held high from the success cycle onward (later ones are spurious).
    task automatic run_vec(input vec_t v, input int idx);
        int mf, exp_k, k, got_k;
        logic [15:0] e0, e1;
        mf = 0;
        if (!v.use0) mf = v.fail0;
        if (!v.use1 && v.fail1 > mf) mf = v.fail1;
        exp_k = (v.use0 && v.use1) ? 1 : 2 + mf;
        e0 = v.use0 ? v.imm0 : v.d0;
        e1 = v.use1 ? v.imm1 : v.d1;
        drive_instr(v);
        @(negedge clk);
        chk($sformatf("v%0d accept_ready", idx), instr_ready_o, 1);
        step();
        instr_valid_i = 1'b0;
        got_k = 0;
        for (k = 1; k <= 40 && got_k == 0; k++) begin
            op0_data_success_i = (k >= 1 + v.fail0);
            op1_data_success_i = (k >= 1 + v.fail1);
            op0_data_i = (!v.use0 && k == 1 + v.fail0) ? v.d0 : 16'hDEAD;
            op1_data_i = (!v.use1 && k == 1 + v.fail1) ? v.d1 : 16'hBEEF;
            @(negedge clk);
            chk($sformatf("v%0d c%0d op0_strobe", idx, k), op0_req_addr_valid_o,
                !v.use0 && k <= 1 + v.fail0);
            chk($sformatf("v%0d c%0d op1_strobe", idx, k), op1_req_addr_valid_o,
                !v.use1 && k <= 1 + v.fail1);
            chk($sformatf("v%0d c%0d stall", idx, k), stall_o, ((k - 1 < mf) ? k - 1 : mf) >= 15);
            chk($sformatf("v%0d c%0d instr_ready", idx, k), instr_ready_o, 0);
            if (op0_req_addr_valid_o) chk($sformatf("v%0d op0_addr", idx), op0_req_addr_o, v.addr0);
            if (op1_req_addr_valid_o) chk($sformatf("v%0d op1_addr", idx), op1_req_addr_o, v.addr1);
            if (alu_valid_o) got_k = k;
            else step();
        end
        if (got_k == 0) begin
            chk($sformatf("v%0d timeout", idx), 0, 1);
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
            idle_inputs();
            return;
        end
        chk($sformatf("v%0d latency", idx), got_k, exp_k);
        for (int h = 0; h <= v.hold; h++) begin
            chk($sformatf("v%0d h%0d op0", idx, h), alu_op0_o, e0);
            chk($sformatf("v%0d h%0d op1", idx, h), alu_op1_o, e1);
            chk($sformatf("v%0d h%0d dest", idx, h), alu_dest_addr_o, v.dest);
            chk($sformatf("v%0d h%0d opcode", idx, h), alu_opcode_o, v.opc);
            chk($sformatf("v%0d h%0d valid", idx, h), alu_valid_o, 1);
            chk($sformatf("v%0d h%0d no_req", idx, h), {op0_req_addr_valid_o, op1_req_addr_valid_o}, 0);
            step();
            @(negedge clk);
        end
        alu_ready_i = 1'b1;
        #1;
        chk($sformatf("v%0d drain_ready", idx), instr_ready_o, 1);
        step();
        idle_inputs();
        @(negedge clk);
        chk($sformatf("v%0d back_idle", idx), {alu_valid_o, instr_ready_o}, 2'b01);
        step();
    endtask

    initial begin
        //           use0  imm0     addr0  f0  d0        use1  imm1     addr1  f1  d1        dest   opc  hold
        vecs[0] = '{1'b1, 16'h0005, 8'h00, 0, 16'h0000, 1'b1, 16'h0007, 8'h00, 0, 16'h0000, 8'h10, 4'h3, 0};
        vecs[1] = '{1'b0, 16'h0000, 8'h02, 0, 16'h00AA, 1'b0, 16'h0000, 8'h03, 2, 16'h00BB, 8'h11, 4'h1, 1};
        vecs[2] = '{1'b1, 16'h1234, 8'h00, 0, 16'h0000, 1'b0, 16'h0000, 8'h09, 1, 16'h55AA, 8'h12, 4'h7, 3};
        vecs[3] = '{1'b0, 16'h0000, 8'h04, 0, 16'h1111, 1'b0, 16'h0000, 8'h04, 0, 16'h2222, 8'h13, 4'h2, 0};
        vecs[4] = '{1'b0, 16'h0000, 8'h06, 20, 16'hC0DE, 1'b1, 16'h0042, 8'h00, 0, 16'h0000, 8'h14, 4'hC, 0};
        vecs[5] = '{1'b1, 16'hFFFF, 8'h00, 0, 16'h0000, 1'b1, 16'h0000, 8'h00, 0, 16'h0000, 8'hFF, 4'hF, 0};
        vecs[6] = '{1'b0, 16'h0000, 8'h21, 3, 16'h3333, 1'b0, 16'h0000, 8'h22, 5, 16'h4444, 8'h15, 4'h5, 2};

        reset_n = 1'b0;
        idle_inputs();
        drive_instr(vecs[0]);
        instr_valid_i = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset ready", instr_ready_o, 1);
        chk("reset valid", alu_valid_o, 0);
        step();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset held mid-FETCH with both requests pending drops the instruction.
        drive_instr(vecs[1]);
        step();
        instr_valid_i = 1'b0;
        @(negedge clk);
        chk("rst pre strobes", {op0_req_addr_valid_o, op1_req_addr_valid_o}, 2'b11);
        step();
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst hold ctrl", {instr_ready_o, alu_valid_o, op0_req_addr_valid_o,
                              op1_req_addr_valid_o, stall_o}, 0);
        step();
        @(negedge clk);
        chk("rst hold addr0", op0_req_addr_o, 0);
        chk("rst hold addr1", op1_req_addr_o, 0);
        chk("rst hold data", {alu_op0_o, alu_op1_o}, 0);
        chk("rst hold dest_opc", {alu_dest_addr_o, alu_opcode_o}, 0);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst release ready", instr_ready_o, 1);
        chk("rst release strobes", {op0_req_addr_valid_o, op1_req_addr_valid_o, alu_valid_o}, 0);
        step();

        // Backpressure for 3 cycles, then back-to-back acceptance of a both-imm instruction.
        drive_instr('{1'b0, 16'h0, 8'h01, 0, 16'h0, 1'b0, 16'h0, 8'h02, 0, 16'h0, 8'h30, 4'h4, 0});
        step();
        instr_valid_i = 1'b0;
        op0_data_success_i = 1'b1; op0_data_i = 16'h0A0A;
        op1_data_success_i = 1'b1; op1_data_i = 16'h0B0B;
        step();
        idle_inputs();
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            chk($sformatf("b2b stall%0d valid", h), alu_valid_o, 1);
            chk($sformatf("b2b stall%0d ops", h), {alu_op0_o, alu_op1_o}, 32'h0A0A0B0B);
            chk($sformatf("b2b stall%0d ready", h), instr_ready_o, 0);
            step();
        end
        alu_ready_i = 1'b1;
        drive_instr('{1'b1, 16'h0033, 8'h0, 0, 16'h0, 1'b1, 16'h0044, 8'h0, 0, 16'h0, 8'h77, 4'h9, 0});
        @(negedge clk);
        chk("b2b handshake ready", instr_ready_o, 1);
        chk("b2b handshake old ops", {alu_op0_o, alu_op1_o}, 32'h0A0A0B0B);
        step();
        idle_inputs();
        @(negedge clk);
        chk("b2b second valid", alu_valid_o, 1);
        chk("b2b second ops", {alu_op0_o, alu_op1_o}, 32'h00330044);
        chk("b2b second dest_opc", {alu_dest_addr_o, alu_opcode_o}, 12'h779);
        step();
        alu_ready_i = 1'b1;
        step();
        alu_ready_i = 1'b0;
        @(negedge clk);
        chk("b2b drained", {alu_valid_o, instr_ready_o}, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
